histogram_run_ctrl: RTL
=======================

Name: histogram_run_ctrl

Overview:
- Run sequencer for the histogram kernel and its 256-bin B result memory.
- On a command it does four things in order: clears all B bins to zero, pulses the kernel start (t / ap_start), owns nothing on the B port while the kernel runs, then streams the B contents out over a valid/ready port.
- Sits between the top-level command interface, the histogram kernel (HIR or HLS variant) and the single-port B memory (memref_wr / memref_rd pair). It muxes the B port between itself and the kernel.

Parameters:
- BINS, 256, number of histogram bins; must be at least 2.
- ADDR_W, 8, B address width; BINS must not exceed 2^ADDR_W.
- DATA_W, 32, B word width.
- TIMEOUT, 4096, watchdog limit in cycles spent in WAIT (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_start  in  1  single-cycle run request; ignored unless the block is in IDLE.
- cmd_dump_en  in  1  sampled with cmd_start; 1 = run DUMP after the kernel finishes.
- cmd_busy  out  1  high in every state except IDLE.
- cmd_done  out  1  one-cycle pulse at the end of a run.
- cmd_err  out  1  timeout flag; stays 0 without HISTO_RUN_CTRL_TIMEOUT_EN.
- k_start  out  1  one-cycle start pulse to the kernel (drives t / ap_start).
- k_done  in  1  kernel completion pulse (ap_done).
- k_B_addr  in  ADDR_W  kernel B address.
- k_B_wr_en  in  1  kernel B write enable.
- k_B_wr_data  in  DATA_W  kernel B write data.
- B_addr  out  ADDR_W  address to B memory.
- B_wr_en  out  1  write enable to B memory.
- B_wr_data  out  DATA_W  write data to B memory.
- B_rd_en  out  1  read enable to B memory.
- B_rd_data  in  DATA_W  read data; valid one cycle after B_rd_en.
- dump_valid  out  1  stream valid.
- dump_ready  in  1  stream ready.
- dump_data  out  DATA_W  bin value.
- dump_last  out  1  high together with the final bin, BINS-1.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, counter = 0, dump_en register = 0. All outputs are 0: cmd_busy, cmd_done, cmd_err, k_start, B_addr, B_wr_en, B_wr_data, B_rd_en, dump_valid, dump_data, dump_last. Reset during any phase aborts the run; there is no partial completion.
- States: IDLE, CLEAR, START, WAIT, DUMP_RD, DUMP_OUT, DONE.
- IDLE:
  - On cmd_start=1, latch cmd_dump_en, set counter = 0 and go to CLEAR.
  - If cmd_start and k_done are high in the same cycle, k_done is ignored.
- CLEAR:
  - Each cycle: B_wr_en=1, B_addr=counter, B_wr_data=0, then counter++.
  - After the write at counter = BINS-1, go to START.
  - Exactly BINS write cycles, back-to-back.
- START: k_start=1 for this one cycle; go to WAIT.
- WAIT:
  - B_addr, B_wr_en and B_wr_data pass through combinationally from the k_B_* inputs.
  - B_rd_en=0.
  - On k_done=1: go to DUMP_RD with counter = 0 if dump_en is set, otherwise go to DONE.
  - k_done arriving in the same cycle as the START pulse is not observed; the kernel's minimum latency is at least 1 cycle.
- Outside WAIT: the k_B_* inputs are ignored, so kernel writes are dropped.
- DUMP_RD: B_rd_en=1, B_addr=counter; go to DUMP_OUT.
- DUMP_OUT:
  - Capture B_rd_data into dump_data on entry.
  - dump_valid=1; dump_last = (counter == BINS-1).
  - dump_data and dump_last are held stable while dump_valid=1 and dump_ready=0.
  - On the handshake (valid & ready): go to DONE if last, else counter++ and go to DUMP_RD.
  - Throughput: at most 1 bin per 2 cycles.
- DONE: cmd_done=1 for one cycle; go to IDLE.
- cmd_start while busy has no effect; it is neither queued nor an error.
- Counter width is ADDR_W+1, which gives no wrap at BINS = 2^ADDR_W. B_addr takes the low ADDR_W bits.
- Run latency with dump disabled: 1 (IDLE) + BINS (CLEAR) + 1 (START) + kernel cycles + 1 (DONE).

Optional Feature:
- Macro: HISTO_RUN_CTRL_TIMEOUT_EN.
- Enabled: a watchdog counter is cleared on entry to WAIT and increments each cycle in WAIT. When it reaches TIMEOUT with no k_done:
  - set cmd_err=1 (sticky until the next accepted cmd_start or reset);
  - skip DUMP and go to DONE; cmd_done still pulses.
  - A k_done arriving in the same cycle as the timeout wins, and no error is set.
- Disabled: no watchdog logic; WAIT lasts until k_done; cmd_err is tied to 0.

Test Plan:
- Clear check: preload B with 0xFFFFFFFF, cmd_start with dump_en=0, stub kernel returns k_done 10 cycles after k_start with no writes -> 256 consecutive zero writes to addresses 0..255; k_start high exactly one cycle; cmd_done at cycle 1+256+1+10+1 after start; all of B = 0.
- Kernel pass-through: in WAIT the stub writes addr 5 = 7 and addr 200 = 3 -> same writes appear on B_*. Writes the stub drives in IDLE or CLEAR never reach B.
- Dump with backpressure: bins i hold i*3, dump_en=1, dump_ready toggles 1,0,0,1 -> 256 beats carrying 0,3,...,765 in order; data stable while stalled; dump_last only on beat 255.
- Busy/ignore: cmd_start pulses during CLEAR and DUMP -> no restart; exactly one cmd_done per accepted start.
- Reset mid-run: assert rst at CLEAR address 100 -> all outputs 0 immediately (asynchronous); after release, a new cmd_start performs a full 256-write clear starting at address 0.
- Timeout (HISTO_RUN_CTRL_TIMEOUT_EN, TIMEOUT=50): no k_done -> cmd_err=1 and cmd_done 50 cycles after WAIT entry, with no dump beats; the next cmd_start clears cmd_err.

Source files
------------

// File: rtl/histogram_run_ctrl_if.sv
// Port bundle for histogram_run_ctrl: command, kernel, B memory and dump stream signals.
// The master modport is the controller's view; slave is the surrounding system's view.
interface histogram_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cmd_start;
    logic              cmd_dump_en;
    logic              cmd_busy;
    logic              cmd_done;
    logic              cmd_err;

    logic              k_start;
    logic              k_done;
    logic [ADDR_W-1:0] k_B_addr;
    logic              k_B_wr_en;
    logic [DATA_W-1:0] k_B_wr_data;

    logic [ADDR_W-1:0] B_addr;
    logic              B_wr_en;
    logic [DATA_W-1:0] B_wr_data;
    logic              B_rd_en;
    logic [DATA_W-1:0] B_rd_data;

    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    modport master (
        input  cmd_start, cmd_dump_en, k_done, k_B_addr, k_B_wr_en, k_B_wr_data,
               B_rd_data, dump_ready,
        output cmd_busy, cmd_done, cmd_err, k_start, B_addr, B_wr_en, B_wr_data,
               B_rd_en, dump_valid, dump_data, dump_last
    );

    modport slave (
        output cmd_start, cmd_dump_en, k_done, k_B_addr, k_B_wr_en, k_B_wr_data,
               B_rd_data, dump_ready,
        input  cmd_busy, cmd_done, cmd_err, k_start, B_addr, B_wr_en, B_wr_data,
               B_rd_en, dump_valid, dump_data, dump_last
    );
endinterface

// File: rtl/histogram_run_ctrl.sv
// histogram_run_ctrl: clears the B bins, starts the kernel, muxes B to it, then streams B out.
// Optional WAIT-phase watchdog with sticky cmd_err: define HISTO_RUN_CTRL_TIMEOUT_EN.
module histogram_run_ctrl #(
    parameter int BINS    = 256,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    histogram_run_ctrl_if.master bus
);
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(BINS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_START, S_WAIT, S_DUMP_RD, S_DUMP_OUT, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dump_en_q, dump_en_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fresh_q;
    logic              timeout_hit;

    if (BINS < 2 || BINS > (1 << ADDR_W) || TIMEOUT < 1) begin : g_param_check
        $error("histogram_run_ctrl: illegal BINS/ADDR_W/TIMEOUT combination");
    end

`ifdef HISTO_RUN_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    assign timeout_hit = (state_q == S_WAIT) && (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        wd_d  = (state_q == S_WAIT) ? wd_q + 1'b1 : '0;
        err_d = err_q;
        if (state_q == S_IDLE && bus.cmd_start) err_d = 1'b0;
        // A k_done in the expiry cycle wins: the run completes normally.
        if (timeout_hit && !bus.k_done) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign bus.cmd_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.cmd_err = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dump_en_q <= 1'b0;
            data_q    <= '0;
            fresh_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dump_en_q <= dump_en_d;
            data_q    <= data_d;
            fresh_q   <= (state_q == S_DUMP_RD);
        end
    end

    // Read data arrives during the first DUMP_OUT cycle; afterwards the captured copy is held.
    assign bus.dump_data = fresh_q ? bus.B_rd_data : data_q;

    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dump_en_d      = dump_en_q;
        data_d         = data_q;
        bus.cmd_busy   = (state_q != S_IDLE);
        bus.cmd_done   = 1'b0;
        bus.k_start    = 1'b0;
        bus.B_addr     = '0;
        bus.B_wr_en    = 1'b0;
        bus.B_wr_data  = '0;
        bus.B_rd_en    = 1'b0;
        bus.dump_valid = 1'b0;
        bus.dump_last  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_start) begin
                    dump_en_d = bus.cmd_dump_en;
                    cnt_d     = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.B_wr_en = 1'b1;
                bus.B_addr  = cnt_q[ADDR_W-1:0];
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_BIN) state_d = S_START;
            end
            S_START: begin
                bus.k_start = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                bus.B_addr    = bus.k_B_addr;
                bus.B_wr_en   = bus.k_B_wr_en;
                bus.B_wr_data = bus.k_B_wr_data;
                if (bus.k_done) begin
                    cnt_d   = '0;
                    state_d = dump_en_q ? S_DUMP_RD : S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DUMP_RD: begin
                bus.B_rd_en = 1'b1;
                bus.B_addr  = cnt_q[ADDR_W-1:0];
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                bus.dump_valid = 1'b1;
                bus.dump_last  = (cnt_q == LAST_BIN);
                if (fresh_q) data_d = bus.B_rd_data;
                if (bus.dump_ready) begin
                    if (cnt_q == LAST_BIN) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_DONE: begin
                bus.cmd_done = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
